// File: rtl/letc_core_stage_f2.sv
// LETC core fetch stage 2: issues the F1 translated address to instruction memory,
// keeps at most one transaction outstanding and hands the returned word to decode.
module letc_core_stage_f2 #(
    parameter int PERF_CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [64:0]           i_f1_to_f2,
    output logic                  o_stage_ready,
    input  logic                  i_stage_flush,
    input  logic                  i_stage_stall,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [33:0]           o_imem_req_addr,
    input  logic                  i_imem_rsp_valid,
    input  logic [31:0]           i_imem_rsp_data,
    input  logic                  i_imem_rsp_fault,
    output logic                  o_f2_to_d_valid,
    output logic [29:0]           o_f2_to_d_pc_word,
    output logic [31:0]           o_f2_to_d_instr,
    output logic                  o_f2_to_d_fault,
    output logic [PERF_CNT_W-1:0] o_perf_wait_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    f1_valid;
    logic [29:0]             f1_pc_word;
    logic [33:0]             f1_fetch_addr;
    logic                    accept;
    logic                    capture_rsp;
    logic [29:0]             pc_word_q;
    logic [33:0]             addr_q;
    logic [31:0]             instr_q;
    logic                    fault_q;
    logic [PERF_CNT_W-1:0]   perf_q;

    // Packed layout of the F1 handoff: {valid, pc_word, fetch_addr}
    assign f1_valid      = i_f1_to_f2[64];
    assign f1_pc_word    = i_f1_to_f2[63:34];
    assign f1_fetch_addr = i_f1_to_f2[33:0];

    assign o_stage_ready = (state_q == IDLE) || ((state_q == HOLD) && !i_stage_stall);
    assign accept        = f1_valid && o_stage_ready && !i_stage_flush;

    assign o_imem_req_valid   = (state_q == REQ) && !i_stage_flush;
    assign o_imem_req_addr    = addr_q;
    assign o_f2_to_d_valid    = (state_q == HOLD) && !i_stage_flush;
    assign o_f2_to_d_pc_word  = pc_word_q;
    assign o_f2_to_d_instr    = instr_q;
    assign o_f2_to_d_fault    = fault_q;
    assign o_perf_wait_cycles = perf_q;

    always_comb begin
        state_d     = state_q;
        capture_rsp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = REQ;
            end
            REQ: begin
                if (i_stage_flush)         state_d = IDLE;
                else if (i_imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                // A flush racing the response can drop it here; otherwise it is still in flight
                if (i_stage_flush) begin
                    state_d = i_imem_rsp_valid ? IDLE : DROP;
                end else if (i_imem_rsp_valid) begin
                    state_d     = HOLD;
                    capture_rsp = 1'b1;
                end
            end
            HOLD: begin
                if (i_stage_flush)       state_d = IDLE;
                else if (!i_stage_stall) state_d = accept ? REQ : IDLE;
            end
            DROP: begin
                if (i_imem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            pc_word_q <= '0;
            addr_q    <= '0;
            instr_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_word_q <= f1_pc_word;
                addr_q    <= f1_fetch_addr & ~34'h3;
            end
            if (capture_rsp) begin
                instr_q <= i_imem_rsp_fault ? 32'h0 : i_imem_rsp_data;
                fault_q <= i_imem_rsp_fault;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_q <= '0;
        end else if (((state_q == REQ) || (state_q == WAIT)) && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_CNT_W'(1);
        end
    end

    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_imem_req_valid && !i_imem_req_ready) |=> $stable(o_imem_req_addr));

    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_f2_to_d_valid && i_stage_stall) |=>
            $stable({o_f2_to_d_pc_word, o_f2_to_d_instr, o_f2_to_d_fault}));

    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rsp_valid |-> ((state_q == WAIT) || (state_q == DROP)));

endmodule
